// File: rtl/reg_file16.sv
// reg_file16: eight-entry, 16-bit register file for the processor datapath.
// One synchronous write port, two combinational read ports with write-first
// bypass, and a debug dump engine that streams every register over a
// valid/ready handshake. Register 0 always reads as zero.
module reg_file16 #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Write-first read of one entry: address 0 is always zero, a same-cycle
  // write to the addressed entry wins over the stored value.
  function automatic logic [DATA_WIDTH-1:0] f_bypass_read(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    logic [DATA_WIDTH-1:0] result;
    if (addr == ZERO_ADDR) begin
      result = ZERO_DATA;
    end else if (wr_en && (wr_addr == addr)) begin
      result = wr_data;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic                  r_dump_valid;
  logic                  r_dump_busy;
  logic                  r_dump_done;

  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] w_next_idx;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_load_idx;
  logic [DATA_WIDTH-1:0] w_snap;
  logic [DATA_WIDTH-1:0] w_rdata_a;
  logic [DATA_WIDTH-1:0] w_rdata_b;

  // Register storage: cleared on reset, writes to entry 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= ZERO_DATA;
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Combinational read ports with write-first bypass.
  always_comb begin
    w_rdata_a = f_bypass_read(raddr_a, r_regs[raddr_a], we, waddr, wdata);
    w_rdata_b = f_bypass_read(raddr_b, r_regs[raddr_b], we, waddr, wdata);
  end

  assign rdata_a = w_rdata_a;
  assign rdata_b = w_rdata_b;

  // Dump engine next-state logic and snapshot-load selection.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_load       = 1'b0;
    w_load_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (dump_start) begin
          w_next_state = S_SEND;
          w_next_idx   = ZERO_ADDR;
          w_load       = 1'b1;
          w_load_idx   = ZERO_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = S_DONE;
          end else begin
            w_next_idx = r_idx + ONE_ADDR;
            w_load     = 1'b1;
            w_load_idx = r_idx + ONE_ADDR;
          end
        end else begin
          w_next_state = S_SEND;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    w_snap = f_bypass_read(w_load_idx, r_regs[w_load_idx], we, waddr, wdata);
  end

  // Dump engine state, index, held snapshot and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= ZERO_ADDR;
      r_dump_data  <= ZERO_DATA;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_idx        <= w_next_idx;
      if (w_load) begin
        r_dump_data <= w_snap;
      end
      r_dump_valid <= (w_next_state == S_SEND);
      r_dump_busy  <= (w_next_state != S_IDLE);
      r_dump_done  <= (w_next_state == S_DONE);
    end
  end

  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_idx;
  assign dump_data  = r_dump_data;
  assign dump_busy  = r_dump_busy;
  assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_reg_file16.sv
// Directed testbench for reg_file16: register read/write, bypass, zero
// register, streaming dump, stalled dump with concurrent write, mid-dump reset.
module tb_reg_file16;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [15:0] rdata_a;
  logic [2:0]  raddr_b;
  logic [15:0] rdata_b;
  logic        dump_start;
  logic        dump_ready;
  logic        dump_valid;
  logic [2:0]  dump_addr;
  logic [15:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  int checks;
  int errors;

  reg_file16 #(.NUM_REGS(8), .DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr_a    (raddr_a),
    .rdata_a    (rdata_a),
    .raddr_b    (raddr_b),
    .rdata_b    (rdata_b),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    we         = 1'b0;
    waddr      = 3'd0;
    wdata      = 16'h0000;
    raddr_a    = 3'd0;
    raddr_b    = 3'd0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    raddr_a = 3'd3;
    raddr_b = 3'd7;
    #1;
    check("rst_valid", {15'd0, dump_valid}, 16'h0000);
    check("rst_busy",  {15'd0, dump_busy},  16'h0000);
    check("rst_done",  {15'd0, dump_done},  16'h0000);
    check("rst_addr",  {13'd0, dump_addr},  16'h0000);
    check("rst_data",  dump_data,           16'h0000);
    check("rst_rda",   rdata_a,             16'h0000);
    check("rst_rdb",   rdata_b,             16'h0000);

    // Basic writes and reads.
    tick();
    we = 1'b1; waddr = 3'd3; wdata = 16'h1234;
    tick();
    waddr = 3'd7; wdata = 16'hBEEF;
    tick();
    we = 1'b0;
    raddr_a = 3'd3; raddr_b = 3'd7;
    #1;
    check("rd_r3", rdata_a, 16'h1234);
    check("rd_r7", rdata_b, 16'hBEEF);
    for (int a = 0; a < 7; a++) begin
      if (a != 3) begin
        raddr_a = 3'(a);
        raddr_b = 3'(a);
        #1;
        check("rd_other_a", rdata_a, 16'h0000);
        check("rd_other_b", rdata_b, 16'h0000);
      end
    end

    // Zero register: write discarded, bypass suppressed.
    tick();
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0;
    #1;
    check("r0_bypass", rdata_a, 16'h0000);
    tick();
    we = 1'b0;
    #1;
    check("r0_stored", rdata_a, 16'h0000);

    // Same-cycle bypass on both ports.
    we = 1'b1; waddr = 3'd5; wdata = 16'hA5A5; raddr_a = 3'd5; raddr_b = 3'd5;
    #1;
    check("byp_a", rdata_a, 16'hA5A5);
    check("byp_b", rdata_b, 16'hA5A5);
    tick();
    we = 1'b0;
    #1;
    check("byp_stored_a", rdata_a, 16'hA5A5);
    check("byp_stored_b", rdata_b, 16'hA5A5);

    // Preload Rn = 0x1000 + n.
    for (int n = 1; n < 8; n++) begin
      we = 1'b1; waddr = 3'(n); wdata = 16'h1000 + 16'(n);
      tick();
    end
    we = 1'b0;

    // Full dump with ready held high.
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("dump_valid", {15'd0, dump_valid}, 16'h0001);
      check("dump_addr",  {13'd0, dump_addr},  16'(k));
      check("dump_data",  dump_data, (k == 0) ? 16'h0000 : (16'h1000 + 16'(k)));
      check("dump_nodone", {15'd0, dump_done}, 16'h0000);
      tick();
    end
    check("done_pulse",  {15'd0, dump_done},  16'h0001);
    check("done_busy",   {15'd0, dump_busy},  16'h0001);
    check("done_valid",  {15'd0, dump_valid}, 16'h0000);
    tick();
    check("after_done",  {15'd0, dump_done},  16'h0000);
    check("after_busy",  {15'd0, dump_busy},  16'h0000);

    // Stalled dump at idx 2 with a concurrent write to R2.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    check("stall_pre_addr", {13'd0, dump_addr}, 16'h0002);
    dump_ready = 1'b0;
    dump_start = 1'b1;
    we = 1'b1; waddr = 3'd2; wdata = 16'h7777; raddr_a = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_valid", {15'd0, dump_valid}, 16'h0001);
      check("stall_addr",  {13'd0, dump_addr},  16'h0002);
      check("stall_data",  dump_data,           16'h1002);
      check("stall_rda",   rdata_a,             16'h7777);
      tick();
      we = 1'b0;
    end
    dump_start = 1'b0;
    dump_ready = 1'b1;
    #1;
    check("resume_addr", {13'd0, dump_addr}, 16'h0002);
    check("resume_data", dump_data,          16'h1002);
    tick();
    check("beat3_data", dump_data, 16'h1003);
    tick();
    check("beat4_addr", {13'd0, dump_addr}, 16'h0004);
    check("beat4_data", dump_data,          16'h1004);

    // Reset in the middle of the dump.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", {15'd0, dump_valid}, 16'h0000);
    check("mrst_busy",  {15'd0, dump_busy},  16'h0000);
    check("mrst_done",  {15'd0, dump_done},  16'h0000);
    check("mrst_addr",  {13'd0, dump_addr},  16'h0000);
    check("mrst_data",  dump_data,           16'h0000);
    for (int a = 1; a < 8; a++) begin
      raddr_a = 3'(a);
      #1;
      check("mrst_reg", rdata_a, 16'h0000);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst_nodone", {15'd0, dump_done}, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
